// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - 3-bit state encoding for the receiver FSM
//   - CPB_MIN: smallest clocks-per-bit divisor the receiver will run with
//   - majority3: 2-of-3 vote used on the sample history
package uart_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [2:0] WAIT_HIGH = 3'd6;

  localparam int CPB_MIN = 4;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: brings the asynchronous serial line into the i_Clock domain
// and produces a noise-filtered bit value.
// Ports:
//   i_Clock      in   system clock
//   i_Reset      in   asynchronous, active-high reset
//   i_Rx_Serial  in   raw serial line, idle high
//   o_Line_Sync  out  line after the 2-flop synchroniser
//   o_Bit_Value  out  majority of the last three synchronised samples
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Rx_Serial,
  output logic o_Line_Sync,
  output logic o_Bit_Value
);

  logic       sync_1;
  logic       sync_2;
  logic [2:0] hist;

  // Everything resets to the idle (high) level so no false start bit is seen.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      hist   <= 3'b111;
    end else begin
      sync_1 <= i_Rx_Serial;
      sync_2 <= sync_1;
      hist   <= {hist[1:0], sync_2};
    end
  end

  assign o_Line_Sync = sync_2;
  assign o_Bit_Value = majority3(hist);

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with 3-sample majority voting,
// runtime divisor, one-entry ready/valid holding register and sticky overrun.
// Build option: define UART_RX_PARITY_EN to include the parity bit
// (PARITY_ODD selects odd parity); otherwise o_Parity_Err is always 0.
// Ports:
//   i_Clock         in   system clock
//   i_Reset         in   asynchronous, active-high reset
//   i_Rx_Serial     in   serial line, idle high
//   i_Clks_Per_Bit  in   clocks per bit, latched at frame start, min 4
//   i_Rx_Ready      in   consumer accepts the held word
//   i_Err_Clr       in   clears o_Overrun
//   o_Rx_Valid      out  held word and status valid until accepted
//   o_Rx_Data       out  received word
//   o_Frame_Err     out  a stop bit sampled low
//   o_Parity_Err    out  parity mismatch
//   o_Break         out  data, parity and stop all low
//   o_Overrun       out  sticky: a frame finished while a word was held
//   o_Busy          out  receiver not idle
//
// state     | meaning
// IDLE      | waiting for synced line low
// START     | half a bit into the start bit; rejects glitches
// DATA      | sampling DATA_BITS bits, LSB first
// PARITY    | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling STOP_BITS stop bits
// DONE      | one clock: publish word or flag overrun
// WAIT_HIGH | line still low after a frame; wait for idle
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int CPB_W      = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic [CPB_W-1:0]     i_Clks_Per_Bit,
  input  logic                 i_Rx_Ready,
  input  logic                 i_Err_Clr,
  output logic                 o_Rx_Valid,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int                IDX_W     = 4;
  localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CPB_W-1:0]  CPB_FLOOR = CPB_W'(CPB_MIN);
  localparam logic [CPB_W-1:0]  ONE       = CPB_W'(1);

  logic [2:0]           state_q, state_d;
  logic                 line_sync, bit_val;
  logic [CPB_W-1:0]     cpb_q, cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q, all_zero_q, par_bit;
  logic                 half_hit, bit_hit, publish;

  uart_rx_sampler u_sampler (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Line_Sync (line_sync),
    .o_Bit_Value (bit_val)
  );

  assign half_hit = (cnt_q == ((cpb_q >> 1) - ONE));
  assign bit_hit  = (cnt_q == (cpb_q - ONE));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!line_sync) state_d = START;
      START:     if (half_hit) state_d = bit_val ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (bit_hit && idx_q == LAST_DATA) state_d = PARITY;
      PARITY:    if (bit_hit) state_d = STOP;
`else
      DATA:      if (bit_hit && idx_q == LAST_DATA) state_d = STOP;
`endif
      STOP:      if (bit_hit && stop_idx_q == LAST_STOP) state_d = DONE;
      DONE:      state_d = line_sync ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (line_sync) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    o_Busy  = (state_q != IDLE);
    publish = (state_q == DONE) && (!o_Rx_Valid || i_Rx_Ready);
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign par_bit = par_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign par_bit = 1'b0;
`endif

  // Frame datapath: bit timer, bit indices, shift register and per-frame flags.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cpb_q       <= CPB_FLOOR;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      all_zero_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Divisor is frozen for the whole frame from here on.
          if (!line_sync)
            cpb_q <= (i_Clks_Per_Bit < CPB_FLOOR) ? CPB_FLOOR : i_Clks_Per_Bit;
        end
        START: begin
          if (half_hit) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_idx_q  <= 1'b0;
            frame_err_q <= 1'b0;
            all_zero_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
          end else cnt_q <= cnt_q + ONE;
        end
        DATA: begin
          if (bit_hit) begin
            cnt_q      <= '0;
            shift_q    <= {bit_val, shift_q[DATA_BITS-1:1]};
            all_zero_q <= all_zero_q & ~bit_val;
            idx_q      <= (idx_q == LAST_DATA) ? '0 : idx_q + IDX_W'(1);
          end else cnt_q <= cnt_q + ONE;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_hit) begin
            cnt_q      <= '0;
            par_err_q  <= bit_val != ((^shift_q) ^ (PARITY_ODD != 0));
            all_zero_q <= all_zero_q & ~bit_val;
          end else cnt_q <= cnt_q + ONE;
        end
`endif
        STOP: begin
          if (bit_hit) begin
            cnt_q       <= '0;
            frame_err_q <= frame_err_q | ~bit_val;
            all_zero_q  <= all_zero_q & ~bit_val;
            stop_idx_q  <= stop_idx_q + 1'b1;
          end else cnt_q <= cnt_q + ONE;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Holding register: a new word replaces the held one only if it is being
  // accepted in the same cycle; otherwise the new word is lost and flagged.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Rx_Valid   <= 1'b0;
      o_Rx_Data    <= '0;
      o_Frame_Err  <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Break      <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      if (publish) begin
        o_Rx_Valid   <= 1'b1;
        o_Rx_Data    <= shift_q;
        o_Frame_Err  <= frame_err_q;
        o_Parity_Err <= par_bit;
        o_Break      <= all_zero_q;
      end else if (o_Rx_Valid && i_Rx_Ready) begin
        o_Rx_Valid <= 1'b0;
      end
      if (state_q == DONE && !publish) o_Overrun <= 1'b1;
      else if (i_Err_Clr)              o_Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
`timescale 1ns/1ps
module tb_uart_rx_ext;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int PODD = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rx0 = 1'b1, rx1 = 1'b1;
  logic [15:0] cpb0 = 16'd16, cpb1 = 16'd16;
  logic        rdy0 = 1'b1, rdy1 = 1'b1, clr0 = 1'b0, clr1 = 1'b0;
  logic        v0, fe0, pe0, brk0, ov0, busy0;
  logic [7:0]  d0;
  logic        v1, fe1, pe1, brk1, ov1, busy1;
  logic [8:0]  d1;

  uart_rx_ext #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PODD), .CPB_W(16)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx0), .i_Clks_Per_Bit(cpb0),
    .i_Rx_Ready(rdy0), .i_Err_Clr(clr0), .o_Rx_Valid(v0), .o_Rx_Data(d0),
    .o_Frame_Err(fe0), .o_Parity_Err(pe0), .o_Break(brk0), .o_Overrun(ov0), .o_Busy(busy0));

  uart_rx_ext #(.DATA_BITS(9), .STOP_BITS(2), .PARITY_ODD(PODD), .CPB_W(16)) dut9 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx1), .i_Clks_Per_Bit(cpb1),
    .i_Rx_Ready(rdy1), .i_Err_Clr(clr1), .o_Rx_Valid(v1), .o_Rx_Data(d1),
    .o_Frame_Err(fe1), .o_Parity_Err(pe1), .o_Break(brk1), .o_Overrun(ov1), .o_Busy(busy1));

  int vectors = 0;
  int errors  = 0;
  int vhi0    = 0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  // Words as seen by the consumer: {break, parity_err, frame_err, data[8:0]}
  always @(negedge clk) begin
    if (!rst) begin
      if (v0 && rdy0) q0.push_back({brk0, pe0, fe0, 1'b0, d0});
      if (v1 && rdy1) q1.push_back({brk1, pe1, fe1, d1});
      if (v0) vhi0++;
    end
  end

  function automatic logic [8:0] mask_data(input logic [8:0] data, input int nbits);
    logic [8:0] m;
    m = 9'h1ff >> (9 - nbits);
    return data & m;
  endfunction

  function automatic bit good_parity(input logic [8:0] data, input int nbits);
    return (($countones(mask_data(data, nbits)) % 2) == 1) ^ (PODD != 0);
  endfunction

  // Reference: what the consumer should see for a frame sent with these bits.
  function automatic logic [11:0] model(input logic [8:0] data, input int nbits,
                                        input bit par, input logic [1:0] stops, input int nstop);
    logic [8:0] d;
    bit fe, pe, brk, stops_low;
    d = mask_data(data, nbits);
    fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    stops_low = (stops[0] == 1'b0) && (nstop == 1 || stops[1] == 1'b0);
    pe = PAR_EN && (par != good_parity(data, nbits));
    brk = (d == 9'd0) && (!PAR_EN || !par) && stops_low;
    return {brk, pe, fe, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic set_cpb(input int which, input logic [15:0] v);
    if (which == 0) cpb0 = v;
    else            cpb1 = v;
  endtask

  task automatic send(input int which, input logic [8:0] data, input int nbits, input int nstop,
                      input bit par, input logic [1:0] stops, input int blen, input int gap,
                      input bit scramble);
    set_line(which, 1'b0);
    tick(blen);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, data[i]);
      if (scramble && i == 0) set_cpb(which, 16'($urandom));
      tick(blen);
    end
    if (PAR_EN) begin
      set_line(which, par);
      tick(blen);
    end
    for (int i = 0; i < nstop; i++) begin
      set_line(which, stops[i]);
      tick(blen);
    end
    set_line(which, 1'b1);
    tick(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    vectors++;
    if ({v0, d0, fe0, pe0, brk0, ov0, busy0} !== 14'd0) begin
      errors++;
      $display("FAIL reset_dut0: got %b want 0", {v0, d0, fe0, pe0, brk0, ov0, busy0});
    end
    vectors++;
    if ({v1, d1, fe1, pe1, brk1, ov1, busy1} !== 15'd0) begin
      errors++;
      $display("FAIL reset_dut9: got %b want 0", {v1, d1, fe1, pe1, brk1, ov1, busy1});
    end
    rst = 1'b0;
    tick(8);
    vectors++;
    if ({v0, busy0, v1, busy1} !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 0000", {v0, busy0, v1, busy1});
    end
  endtask

  task automatic test_basic();
    int vh;
    logic [11:0] got, exp;
    q0.delete();
    rdy0 = 1'b1;
    cpb0 = 16'd16;
    vh = vhi0;
    exp = model(9'h0A5, 8, good_parity(9'h0A5, 8), 2'b11, 1);
    send(0, 9'h0A5, 8, 1, good_parity(9'h0A5, 8), 2'b11, 16, 48, 1'b0);
    vectors++;
    if (q0.size() != 1) begin
      errors++;
      $display("FAIL basic_count: got %0d words want 1", q0.size());
    end else begin
      got = q0.pop_front();
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_word: got %h want %h", got, exp);
      end
    end
    vectors++;
    if (vhi0 - vh != 1) begin
      errors++;
      $display("FAIL basic_valid_width: got %0d cycles want 1", vhi0 - vh);
    end
  endtask

  task automatic test_glitch();
    int vh;
    bit saw;
    q0.delete();
    cpb0 = 16'd16;
    vh = vhi0;
    saw = 1'b0;
    set_line(0, 1'b0);
    tick(1);
    set_line(0, 1'b1);
    for (int t = 0; t < 40; t++) begin
      tick(1);
      if (busy0) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy seen %0d want 1", saw);
    end
    vectors++;
    if (busy0 !== 1'b0 || vhi0 != vh || q0.size() != 0) begin
      errors++;
      $display("FAIL glitch_abort: busy %b valid cycles %0d words %0d want 0 0 0",
               busy0, vhi0 - vh, q0.size());
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [11:0] got;
    q0.delete();
    cpb0 = 16'd16;
    send(0, 9'h003, 8, 1, 1'b1, 2'b11, 16, 48, 1'b0);
    vectors++;
    if (q0.size() != 1) begin
      errors++;
      $display("FAIL parity_count: got %0d words want 1", q0.size());
    end else begin
      got = q0.pop_front();
      vectors++;
      if (got !== 12'h403) begin
        errors++;
        $display("FAIL parity_word: got %h want %h", got, 12'h403);
      end
    end
  endtask
`endif

  task automatic test_break();
    int flen;
    logic [11:0] got, exp;
    q0.delete();
    cpb0 = 16'd16;
    flen = 1 + 8 + (PAR_EN ? 1 : 0) + 1;
    exp = model(9'd0, 8, 1'b0, 2'b00, 1);
    set_line(0, 1'b0);
    tick(2 * flen * 16);
    vectors++;
    if (q0.size() != 1) begin
      errors++;
      $display("FAIL break_count: got %0d words want 1", q0.size());
    end else begin
      got = q0.pop_front();
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL break_word: got %h want %h", got, exp);
      end
    end
    vectors++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL break_hold: busy %b want 1", busy0);
    end
    set_line(0, 1'b1);
    tick(40);
    vectors++;
    if (busy0 !== 1'b0 || q0.size() != 0) begin
      errors++;
      $display("FAIL break_release: busy %b words %0d want 0 0", busy0, q0.size());
    end
  endtask

  task automatic test_overrun();
    logic [11:0] got;
    q0.delete();
    cpb0 = 16'd16;
    rdy0 = 1'b0;
    send(0, 9'h011, 8, 1, good_parity(9'h011, 8), 2'b11, 16, 48, 1'b0);
    send(0, 9'h022, 8, 1, good_parity(9'h022, 8), 2'b11, 16, 48, 1'b0);
    vectors++;
    if ({v0, d0, ov0, fe0, pe0, brk0} !== {1'b1, 8'h11, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL overrun_hold: got v%b d%h ov%b err%b want v1 d11 ov1 err000",
               v0, d0, ov0, {fe0, pe0, brk0});
    end
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    tick(1);
    vectors++;
    if ({v0, ov0} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_clear: got v%b ov%b want v1 ov0", v0, ov0);
    end
    rdy0 = 1'b1;
    tick(3);
    vectors++;
    if (v0 !== 1'b0 || q0.size() != 1) begin
      errors++;
      $display("FAIL overrun_accept: valid %b words %0d want 0 1", v0, q0.size());
    end else begin
      got = q0.pop_front();
      vectors++;
      if (got !== model(9'h011, 8, good_parity(9'h011, 8), 2'b11, 1)) begin
        errors++;
        $display("FAIL overrun_word: got %h want %h", got,
                 model(9'h011, 8, good_parity(9'h011, 8), 2'b11, 1));
      end
    end
  endtask

  task automatic test_random(input int which, input int nframes);
    logic [8:0] data;
    logic [1:0] stops;
    logic [11:0] got, exp;
    int cfg, blen, nbits, nstop;
    bit par;
    nbits = (which == 0) ? 8 : 9;
    nstop = (which == 0) ? 1 : 2;
    q0.delete();
    q1.delete();
    for (int i = 0; i < nframes; i++) begin
      data  = 9'($urandom);
      cfg   = $urandom_range(0, 24);
      blen  = (cfg < 4) ? 4 : cfg;
      stops = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
      par   = good_parity(data, nbits) ^ ($urandom_range(0, 3) == 0);
      exp   = model(data, nbits, par, stops, nstop);
      set_cpb(which, 16'(cfg));
      send(which, data, nbits, nstop, par, stops, blen, 3 * blen + 8, 1'($urandom_range(0, 1)));
      vectors++;
      if (which == 0 && q0.size() == 1) got = q0.pop_front();
      else if (which == 1 && q1.size() == 1) got = q1.pop_front();
      else got = 12'hfff;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d_frame%0d: got %h want %h (cpb %0d)", which, i, got, exp, cfg);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] data[3];
    logic [11:0] got, exp;
    q0.delete();
    cpb0 = 16'd16;
    for (int i = 0; i < 3; i++) data[i] = {1'b0, 8'($urandom)};
    for (int i = 0; i < 3; i++)
      send(0, data[i], 8, 1, good_parity(data[i], 8), 2'b11, 16, (i == 2) ? 48 : 0, 1'b0);
    vectors++;
    if (q0.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d words want 3", q0.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        got = q0.pop_front();
        exp = model(data[i], 8, good_parity(data[i], 8), 2'b11, 1);
        vectors++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h want %h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] got, exp;
    q1.delete();
    cpb1 = 16'd139;
    exp = model(9'h1ff, 9, good_parity(9'h1ff, 9), 2'b11, 2);
    send(1, 9'h1ff, 9, 2, good_parity(9'h1ff, 9), 2'b11, 139, 300, 1'b0);
    vectors++;
    got = (q1.size() == 1) ? q1.pop_front() : 12'hfff;
    if (got !== exp) begin
      errors++;
      $display("FAIL wide_word: got %h want %h", got, exp);
    end
    set_line(1, 1'b0);
    tick(139);
    set_line(1, 1'b1);
    tick(139);
    set_line(1, 1'b0);
    tick(70);
    vectors++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL wide_midframe_busy: got %b want 1", busy1);
    end
    rst = 1'b1;
    set_line(1, 1'b1);
    tick(2);
    vectors++;
    if ({v1, d1, fe1, pe1, brk1, ov1, busy1} !== 15'd0) begin
      errors++;
      $display("FAIL wide_reset_outputs: got %b want 0", {v1, d1, fe1, pe1, brk1, ov1, busy1});
    end
    rst = 1'b0;
    tick(12 * 139);
    vectors++;
    if (q1.size() != 0 || v1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL wide_discard: words %0d valid %b busy %b want 0 0 0", q1.size(), v1, busy1);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_glitch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_break();
    test_overrun();
    test_random(0, 24);
    test_random(1, 8);
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
